// File: rtl/fetch_control_unit.sv
// Purpose: owns the fetch PC and runs a single-outstanding request/response fetch from instruction memory.
// Latency: a response is presented in the same cycle it arrives; at best one instruction every 2 cycles.
// Backpressure: stall_in parks an arrived instruction in a hold buffer; redirects squash in-flight fetches.
module fetch_control_unit #(
  parameter int                       DATA_WIDTH   = 32,
  parameter int                       ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0]  RESET_PC     = '0,
  parameter int                       MAX_WAIT     = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall_in,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  output logic                    imem_req,
  output logic [ADDRESS_BITS-1:0] imem_addr,
  input  logic                    imem_ready,
  input  logic                    imem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   imem_resp_data,
  output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
  output logic [DATA_WIDTH-1:0]   instruction_fetch,
  output logic                    fetch_valid,
  output logic                    fetch_stall,
  output logic                    timeout_error
);

  localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(32'h00000013);
  localparam logic [7:0]            MAX_WAIT_C = 8'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [ADDRESS_BITS-1:0] pc, pc_nxt, pc_inc;
  logic [ADDRESS_BITS-1:0] hold_pc, hold_pc_nxt;
  logic [DATA_WIDTH-1:0]   hold_inst, hold_inst_nxt;
  logic                    squash, squash_nxt;
  logic [7:0]              wait_cnt, wait_cnt_nxt;
  logic                    timeout_nxt;

  // PC increments wrap naturally at the address width.
  assign pc_inc      = pc + ADDRESS_BITS'(4);
  assign imem_addr   = pc;
  assign fetch_stall = stall_in;

  // Next-state and output decode; redirect outranks everything except reset.
  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc;
    squash_nxt        = squash;
    hold_pc_nxt       = hold_pc;
    hold_inst_nxt     = hold_inst;
    wait_cnt_nxt      = wait_cnt;
    timeout_nxt       = timeout_error;
    imem_req          = 1'b0;
    fetch_valid       = 1'b0;
    instruction_fetch = NOP;
    inst_PC_fetch     = pc;

    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_valid) pc_nxt = redirect_target;
      end

      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = '0;
          // A redirect in the accept cycle makes the accepted request stale.
          squash_nxt   = redirect_valid;
        end
        if (redirect_valid) pc_nxt = redirect_target;
      end

      WAIT: begin
        if (imem_resp_valid) begin
          state_nxt  = REQ;
          squash_nxt = 1'b0;
          if (redirect_valid) begin
            pc_nxt = redirect_target;
          end else if (!squash) begin
            pc_nxt = pc_inc;
            if (!stall_in) begin
              fetch_valid       = 1'b1;
              instruction_fetch = imem_resp_data;
            end else begin
              hold_inst_nxt = imem_resp_data;
              hold_pc_nxt   = pc;
              state_nxt     = HOLD;
            end
          end
        end else begin
          wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
          if (wait_cnt_nxt >= MAX_WAIT_C) timeout_nxt = 1'b1;
          if (redirect_valid) begin
            pc_nxt     = redirect_target;
            squash_nxt = 1'b1;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          state_nxt = REQ;
        end else begin
          fetch_valid       = 1'b1;
          instruction_fetch = hold_inst;
          inst_PC_fetch     = hold_pc;
          if (!stall_in) state_nxt = REQ;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // While reset is held nothing is requested or presented.
    if (reset) begin
      imem_req          = 1'b0;
      fetch_valid       = 1'b0;
      instruction_fetch = NOP;
      inst_PC_fetch     = pc;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      squash        <= 1'b0;
      hold_pc       <= RESET_PC;
      hold_inst     <= NOP;
      wait_cnt      <= '0;
      timeout_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      squash        <= squash_nxt;
      hold_pc       <= hold_pc_nxt;
      hold_inst     <= hold_inst_nxt;
      wait_cnt      <= wait_cnt_nxt;
      timeout_error <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: directed scenarios plus a randomized run checked by a PC-stream scoreboard.
// Inputs change just after the falling edge; outputs are sampled 1ns later, before the rising edge.
// The bench memory holds at most one outstanding request and answers after a programmable latency.
module tb_fetch_control_unit;
  localparam int AB = 20;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall_in = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AB-1:0] redirect_target = '0;
  logic          imem_req;
  logic [AB-1:0] imem_addr;
  logic          imem_ready = 1'b0;
  logic          imem_resp_valid = 1'b0;
  logic [DW-1:0] imem_resp_data = '0;
  logic [AB-1:0] inst_PC_fetch;
  logic [DW-1:0] instruction_fetch;
  logic          fetch_valid;
  logic          fetch_stall;
  logic          timeout_error;

  int n_cmp = 0;
  int n_err = 0;

  // bench memory / driver configuration
  bit            rst_req = 1'b1;
  bit            ready_dflt = 1'b1;
  bit            mem_busy = 1'b0;
  int            mem_cnt = 0;
  logic [AB-1:0] mem_addr = '0;
  int            mem_lat = 1;
  bit            mem_lat_rand = 1'b0;
  bit            mem_withhold = 1'b0;
  bit            spurious_en = 1'b0;

  fetch_control_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .RESET_PC('0), .MAX_WAIT(15)) dut (
    .clock(clock), .reset(reset), .stall_in(stall_in),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_PC_fetch(inst_PC_fetch), .instruction_fetch(instruction_fetch),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [AB-1:0] a);
    if (a == 20'h00008) return 32'h00500093;
    return {12'hA5C, a};
  endfunction

  // Falling edge: apply default inputs and the memory's response for this cycle.
  task automatic begin_cycle();
    @(negedge clock);
    reset           = rst_req;
    stall_in        = 1'b0;
    redirect_valid  = 1'b0;
    imem_ready      = ready_dflt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_busy && !mem_withhold) begin
      mem_cnt--;
      if (mem_cnt <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
        mem_busy        = 1'b0;
      end
    end else if (!mem_busy && spurious_en && $urandom_range(7) == 0) begin
      imem_resp_valid = 1'b1;
    end
  endtask

  // Record a handshake seen this cycle, then take the rising edge.
  task automatic end_cycle();
    if (imem_req && imem_ready) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = mem_lat_rand ? int'($urandom_range(3, 1)) : mem_lat;
    end
    @(posedge clock);
  endtask

  task automatic do_reset();
    rst_req = 1'b1; mem_busy = 1'b0; mem_withhold = 1'b0; spurious_en = 1'b0;
    mem_lat_rand = 1'b0; mem_lat = 1; ready_dflt = 1'b1;
    repeat (2) begin begin_cycle(); #1; end_cycle(); end
    rst_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_req = 1'b1; mem_busy = 1'b0; ready_dflt = 1'b1;
    for (int k = 0; k < 2; k++) begin
      begin_cycle(); stall_in = 1'b1; #1;
      if (k == 1) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b want 0", imem_req); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", fetch_valid); end
        n_cmp++; if (instruction_fetch !== NOP) begin n_err++; $display("FAIL rst_inst got %h want %h", instruction_fetch, NOP); end
        n_cmp++; if (inst_PC_fetch !== 20'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", inst_PC_fetch); end
        n_cmp++; if (timeout_error !== 1'b0) begin n_err++; $display("FAIL rst_timeout got %0b want 0", timeout_error); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall got %0b want 1", fetch_stall); end
      end
      end_cycle();
    end
    rst_req = 1'b0;
    begin_cycle(); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req got %0b want 0", imem_req); end
    end_cycle();
    begin_cycle(); #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'h0) begin n_err++; $display("FAIL first_req got %0b/%h want 1/0", imem_req, imem_addr); end
    end_cycle();
  endtask

  task automatic test_sequential();
    logic [AB-1:0] ea;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      begin_cycle(); #1;
      n_cmp++; if (imem_req !== (k % 2 == 1)) begin n_err++; $display("FAIL seq_req k=%0d got %0b", k, imem_req); end
      if (k % 2 == 1) begin
        ea = AB'((k - 1) / 2 * 4);
        n_cmp++; if (imem_addr !== ea) begin n_err++; $display("FAIL seq_addr k=%0d got %h want %h", k, imem_addr, ea); end
      end
      n_cmp++; if (fetch_valid !== (k >= 2 && k % 2 == 0)) begin n_err++; $display("FAIL seq_valid k=%0d got %0b", k, fetch_valid); end
      if (k >= 2 && k % 2 == 0) begin
        ea = AB'((k - 2) / 2 * 4);
        n_cmp++; if (inst_PC_fetch !== ea || instruction_fetch !== mem_word(ea)) begin
          n_err++; $display("FAIL seq_out k=%0d got %h/%h want %h/%h", k, inst_PC_fetch, instruction_fetch, ea, mem_word(ea)); end
      end else begin
        n_cmp++; if (instruction_fetch !== NOP) begin n_err++; $display("FAIL seq_nop k=%0d got %h", k, instruction_fetch); end
      end
      end_cycle();
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < 11; k++) begin
      begin_cycle(); stall_in = (k >= 6 && k <= 8); #1;
      if (k == 6) begin
        n_cmp++; if (fetch_valid !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL hold_enter got v=%0b s=%0b want 0/1", fetch_valid, fetch_stall); end
      end
      if (k >= 7 && k <= 9) begin
        n_cmp++; if (fetch_valid !== 1'b1 || instruction_fetch !== 32'h00500093 || inst_PC_fetch !== 20'h8) begin
          n_err++; $display("FAIL hold_out k=%0d got %0b/%h/%h want 1/00500093/00008", k, fetch_valid, instruction_fetch, inst_PC_fetch); end
      end
      if (k == 10) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'hC) begin n_err++; $display("FAIL hold_next got %0b/%h want 1/0000c", imem_req, imem_addr); end
      end
      end_cycle();
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(); mem_lat = 2;
    for (int k = 0; k < 10; k++) begin
      begin_cycle();
      if (k == 5) begin redirect_valid = 1'b1; redirect_target = 20'h00100; end
      #1;
      if (k == 3) begin
        n_cmp++; if (fetch_valid !== 1'b1 || inst_PC_fetch !== 20'h0) begin n_err++; $display("FAIL rw_first got %0b/%h want 1/0", fetch_valid, inst_PC_fetch); end
      end
      if (k == 5 || k == 6) begin
        n_cmp++; if (fetch_valid !== 1'b0 || instruction_fetch !== NOP) begin n_err++; $display("FAIL rw_drop k=%0d got %0b/%h want 0/NOP", k, fetch_valid, instruction_fetch); end
      end
      if (k == 7) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'h00100) begin n_err++; $display("FAIL rw_addr got %0b/%h want 1/00100", imem_req, imem_addr); end
      end
      if (k == 9) begin
        n_cmp++; if (fetch_valid !== 1'b1 || inst_PC_fetch !== 20'h00100 || instruction_fetch !== mem_word(20'h00100)) begin
          n_err++; $display("FAIL rw_tgt got %0b/%h/%h want 1/00100", fetch_valid, inst_PC_fetch, instruction_fetch); end
      end
      end_cycle();
    end
  endtask

  task automatic test_redirect_accept();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      begin_cycle();
      if (k == 5) begin redirect_valid = 1'b1; redirect_target = 20'h00040; end
      #1;
      if (k == 5) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'h8) begin n_err++; $display("FAIL ra_req got %0b/%h want 1/00008", imem_req, imem_addr); end
      end
      if (k == 6) begin
        n_cmp++; if (fetch_valid !== 1'b0 || instruction_fetch !== NOP) begin n_err++; $display("FAIL ra_stale got %0b/%h want 0/NOP", fetch_valid, instruction_fetch); end
      end
      if (k == 7) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'h00040) begin n_err++; $display("FAIL ra_addr got %0b/%h want 1/00040", imem_req, imem_addr); end
      end
      if (k == 8) begin
        n_cmp++; if (fetch_valid !== 1'b1 || inst_PC_fetch !== 20'h00040 || instruction_fetch !== mem_word(20'h00040)) begin
          n_err++; $display("FAIL ra_tgt got %0b/%h/%h want 1/00040", fetch_valid, inst_PC_fetch, instruction_fetch); end
      end
      end_cycle();
    end
  endtask

  task automatic test_timeout();
    do_reset(); mem_withhold = 1'b1;
    for (int k = 0; k < 22; k++) begin
      begin_cycle(); #1;
      if (k >= 2) begin
        n_cmp++; if (timeout_error !== (k >= 17)) begin n_err++; $display("FAIL to_flag wait_cycle=%0d got %0b want %0b", k - 1, timeout_error, k >= 17); end
      end
      end_cycle();
    end
    mem_withhold = 1'b0;
    for (int k = 0; k < 5; k++) begin
      begin_cycle(); #1;
      if (k == 0) begin
        n_cmp++; if (fetch_valid !== 1'b1 || inst_PC_fetch !== 20'h0) begin n_err++; $display("FAIL to_late got %0b/%h want 1/0", fetch_valid, inst_PC_fetch); end
      end
      n_cmp++; if (timeout_error !== 1'b1) begin n_err++; $display("FAIL to_sticky k=%0d got %0b want 1", k, timeout_error); end
      end_cycle();
    end
    do_reset();
    begin_cycle(); #1;
    n_cmp++; if (timeout_error !== 1'b0) begin n_err++; $display("FAIL to_clear got %0b want 0", timeout_error); end
    end_cycle();
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin rst_req = 1'b1; mem_withhold = 1'b1; end
      if (k == 5) begin rst_req = 1'b0; mem_withhold = 1'b0; end
      begin_cycle();
      if (k == 0) begin redirect_valid = 1'b1; redirect_target = 20'hFFFFC; end
      #1;
      if (k == 1) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'hFFFFC) begin n_err++; $display("FAIL wr_top got %0b/%h want 1/ffffc", imem_req, imem_addr); end
      end
      if (k == 2) begin
        n_cmp++; if (fetch_valid !== 1'b1 || inst_PC_fetch !== 20'hFFFFC) begin n_err++; $display("FAIL wr_out got %0b/%h want 1/ffffc", fetch_valid, inst_PC_fetch); end
      end
      if (k == 3) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'h0) begin n_err++; $display("FAIL wr_wrap got %0b/%h want 1/00000", imem_req, imem_addr); end
      end
      if (k == 4 || k == 5) begin
        n_cmp++; if (fetch_valid !== 1'b0 || instruction_fetch !== NOP || imem_req !== 1'b0 || inst_PC_fetch !== 20'h0) begin
          n_err++; $display("FAIL wr_rst k=%0d got v=%0b i=%h r=%0b pc=%h", k, fetch_valid, instruction_fetch, imem_req, inst_PC_fetch); end
      end
      if (k == 6) begin
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 20'h0) begin n_err++; $display("FAIL wr_restart got %0b/%h want 1/0", imem_req, imem_addr); end
      end
      if (k == 7) begin
        n_cmp++; if (fetch_valid !== 1'b1 || inst_PC_fetch !== 20'h0) begin n_err++; $display("FAIL wr_refetch got %0b/%h want 1/0", fetch_valid, inst_PC_fetch); end
      end
      end_cycle();
    end
  endtask

  // Scoreboard: captured instructions must follow the PC stream (sequential, restarted by each redirect).
  task automatic test_random();
    logic [AB-1:0] exp_pc;
    logic [31:0]   r;
    int            captures;
    do_reset(); mem_lat_rand = 1'b1; spurious_en = 1'b1;
    exp_pc = '0; captures = 0;
    for (int i = 0; i < 3000; i++) begin
      begin_cycle();
      imem_ready     = ($urandom_range(3) != 0);
      stall_in       = ($urandom_range(3) == 0);
      redirect_valid = ($urandom_range(19) == 0);
      r = $urandom;
      redirect_target = ($urandom_range(3) == 0) ? 20'hFFFF8 : {r[AB-1:2], 2'b00};
      #1;
      n_cmp++; if (fetch_stall !== stall_in) begin n_err++; $display("FAIL rnd_stall i=%0d got %0b want %0b", i, fetch_stall, stall_in); end
      if (!fetch_valid) begin
        n_cmp++; if (instruction_fetch !== NOP) begin n_err++; $display("FAIL rnd_nop i=%0d got %h", i, instruction_fetch); end
      end
      if (redirect_valid) begin
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL rnd_redir_valid i=%0d got %0b want 0", i, fetch_valid); end
      end
      if (imem_req && imem_ready && !redirect_valid) begin
        n_cmp++; if (imem_addr !== exp_pc) begin n_err++; $display("FAIL rnd_addr i=%0d got %h want %h", i, imem_addr, exp_pc); end
      end
      if (fetch_valid && !stall_in) begin
        n_cmp++; if (inst_PC_fetch !== exp_pc || instruction_fetch !== mem_word(exp_pc)) begin
          n_err++; $display("FAIL rnd_capture i=%0d got %h/%h want %h/%h", i, inst_PC_fetch, instruction_fetch, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 20'd4;
        captures++;
      end
      if (redirect_valid) exp_pc = redirect_target;
      end_cycle();
    end
    n_cmp++; if (captures < 200) begin n_err++; $display("FAIL rnd_progress got %0d captures want >= 200", captures); end
    n_cmp++; if (timeout_error !== 1'b0) begin n_err++; $display("FAIL rnd_timeout got %0b want 0", timeout_error); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_redirect_wait();
    test_redirect_accept();
    test_timeout();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
